// File: rtl/umai_pkg.sv
// Shared UMAI bus widths, line geometry and responder FSM state types.
package umai_pkg;

    localparam int AddrW     = 32;
    localparam int LenW      = 6;
    localparam int DataW     = 512;
    localparam int BeatBytes = 64;
    localparam int LineOff   = 6;

    typedef enum logic {
        W_IDLE,
        W_DATA
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    // Byte address to absolute line number; callers truncate to their depth.
    function automatic logic [AddrW-1:0] line_of(input logic [AddrW-1:0] addr);
        return addr >> LineOff;
    endfunction

endpackage

// File: rtl/umai_resp_mem.sv
// Line memory for the UMAI responder: one write port, one registered
// read port with read-before-write behaviour on a same-line collision.
module umai_resp_mem
    import umai_pkg::*;
#(
    parameter int Depth = 64,
    localparam int IdxW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IdxW-1:0]  wr_idx,
    input  logic [DataW-1:0] wr_data,
    input  logic             rd_en,
    input  logic [IdxW-1:0]  rd_idx,
    output logic [DataW-1:0] rd_data
);

    logic [DataW-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/umai_mem_responder.sv
// Behavioural UMAI target: independent write and read burst engines
// in front of a line-addressed memory.
module umai_mem_responder
    import umai_pkg::*;
#(
    parameter int Depth = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_umai_wcmd_valid,
    output logic             o_umai_wcmd_ready,
    input  logic [AddrW-1:0] i_umai_wcmd_addr,
    input  logic [LenW-1:0]  i_umai_wcmd_len,
    input  logic             i_umai_rcmd_valid,
    output logic             o_umai_rcmd_ready,
    input  logic [AddrW-1:0] i_umai_rcmd_addr,
    input  logic [LenW-1:0]  i_umai_rcmd_len,
    input  logic             i_umai_wvalid,
    output logic             o_umai_wready,
    input  logic [DataW-1:0] i_umai_wdata,
    output logic             o_umai_rvalid,
    input  logic             i_umai_rready,
    output logic [DataW-1:0] o_umai_rdata,
    output logic             o_wr_busy,
    output logic             o_rd_busy
);

    localparam int IdxW = $clog2(Depth);

    wr_state_e        w_state, w_state_nxt;
    logic [IdxW-1:0]  w_idx, w_idx_nxt;
    logic [LenW-1:0]  w_cnt, w_cnt_nxt;
    rd_state_e        r_state, r_state_nxt;
    logic [IdxW-1:0]  r_idx, r_idx_nxt;
    logic [LenW-1:0]  r_cnt, r_cnt_nxt;

    logic             mem_we;
    logic [IdxW-1:0]  mem_widx;
    logic             mem_re;
    logic [IdxW-1:0]  mem_ridx;
    logic [IdxW-1:0]  wcmd_line;
    logic [IdxW-1:0]  rcmd_line;

    assign wcmd_line = IdxW'(line_of(i_umai_wcmd_addr));
    assign rcmd_line = IdxW'(line_of(i_umai_rcmd_addr));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w_state <= W_IDLE;
            w_idx   <= '0;
            w_cnt   <= '0;
            r_state <= R_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            w_state <= w_state_nxt;
            w_idx   <= w_idx_nxt;
            w_cnt   <= w_cnt_nxt;
            r_state <= r_state_nxt;
            r_idx   <= r_idx_nxt;
            r_cnt   <= r_cnt_nxt;
        end
    end

    // w_cnt holds the beats remaining after the current one.
    always_comb begin
        w_state_nxt       = w_state;
        w_idx_nxt         = w_idx;
        w_cnt_nxt         = w_cnt;
        o_umai_wcmd_ready = 1'b0;
        o_umai_wready     = 1'b0;
        mem_we            = 1'b0;
        mem_widx          = w_idx;
        unique case (w_state)
            W_IDLE: begin
                o_umai_wcmd_ready = 1'b1;
                if (i_umai_wcmd_valid) begin
                    w_idx_nxt   = wcmd_line;
                    w_cnt_nxt   = i_umai_wcmd_len;
                    w_state_nxt = W_DATA;
                end
            end
            W_DATA: begin
                o_umai_wready = 1'b1;
                if (i_umai_wvalid) begin
                    mem_we    = 1'b1;
                    w_idx_nxt = w_idx + IdxW'(1);
                    w_cnt_nxt = w_cnt - LenW'(1);
                    if (w_cnt == '0) begin
                        w_state_nxt = W_IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    // The first beat is loaded at command accept; later beats on each handshake.
    always_comb begin
        r_state_nxt       = r_state;
        r_idx_nxt         = r_idx;
        r_cnt_nxt         = r_cnt;
        o_umai_rcmd_ready = 1'b0;
        o_umai_rvalid     = 1'b0;
        mem_re            = 1'b0;
        mem_ridx          = r_idx;
        unique case (r_state)
            R_IDLE: begin
                o_umai_rcmd_ready = 1'b1;
                if (i_umai_rcmd_valid) begin
                    mem_re      = 1'b1;
                    mem_ridx    = rcmd_line;
                    r_idx_nxt   = rcmd_line + IdxW'(1);
                    r_cnt_nxt   = i_umai_rcmd_len;
                    r_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                o_umai_rvalid = 1'b1;
                if (i_umai_rready) begin
                    if (r_cnt == '0) begin
                        r_state_nxt = R_IDLE;
                    end else begin
                        mem_re    = 1'b1;
                        r_idx_nxt = r_idx + IdxW'(1);
                        r_cnt_nxt = r_cnt - LenW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign o_wr_busy = (w_state == W_DATA);
    assign o_rd_busy = (r_state == R_DATA);

    // A beat arriving alongside reset belongs to the abandoned burst.
    umai_resp_mem #(
        .Depth(Depth)
    ) u_mem (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (mem_we & ~i_rst),
        .wr_idx  (mem_widx),
        .wr_data (i_umai_wdata),
        .rd_en   (mem_re),
        .rd_idx  (mem_ridx),
        .rd_data (o_umai_rdata)
    );

endmodule

// File: tb/tb_umai_mem_responder.sv
// Randomised self-checking bench for umai_mem_responder against an
// array-based memory model indexed by line number.
module tb_umai_mem_responder;

    localparam int D = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wcmd_valid = 1'b0;
    logic         wcmd_ready;
    logic [31:0]  wcmd_addr = '0;
    logic [5:0]   wcmd_len = '0;
    logic         rcmd_valid = 1'b0;
    logic         rcmd_ready;
    logic [31:0]  rcmd_addr = '0;
    logic [5:0]   rcmd_len = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [511:0] wdata = '0;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [511:0] rdata;
    logic         wr_busy;
    logic         rd_busy;

    logic [511:0] model [D];
    logic [511:0] rq [$];
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    umai_mem_responder #(.Depth(D)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_umai_wcmd_valid (wcmd_valid),
        .o_umai_wcmd_ready (wcmd_ready),
        .i_umai_wcmd_addr  (wcmd_addr),
        .i_umai_wcmd_len   (wcmd_len),
        .i_umai_rcmd_valid (rcmd_valid),
        .o_umai_rcmd_ready (rcmd_ready),
        .i_umai_rcmd_addr  (rcmd_addr),
        .i_umai_rcmd_len   (rcmd_len),
        .i_umai_wvalid     (wvalid),
        .o_umai_wready     (wready),
        .i_umai_wdata      (wdata),
        .o_umai_rvalid     (rvalid),
        .i_umai_rready     (rready),
        .o_umai_rdata      (rdata),
        .o_wr_busy         (wr_busy),
        .o_rd_busy         (rd_busy)
    );

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 6) % D);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a write burst from idle; the model records every beat.
    task automatic do_write(input logic [31:0] addr, input int len);
        int ln;
        ln = line_of(addr);
        wcmd_valid = 1'b1;
        wcmd_addr = addr;
        wcmd_len = 6'(len);
        tick();
        wcmd_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1;
            wdata = rnd512();
            tick();
            model[(ln + i) % D] = wdata;
        end
        wvalid = 1'b0;
    endtask

    // Issue a read burst and collect accepted beats into rq (bounded).
    task automatic do_read(input logic [31:0] addr, input int len, input bit rnd_ready);
        rq.delete();
        rcmd_valid = 1'b1;
        rcmd_addr = addr;
        rcmd_len = 6'(len);
        tick();
        rcmd_valid = 1'b0;
        for (int c = 0; c < 400 && rq.size() <= len; c++) begin
            rready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rvalid && rready) rq.push_back(rdata);
            tick();
        end
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({wcmd_ready, rcmd_ready, wready, rvalid, wr_busy, rd_busy} !== 6'b110000)
            $display("FAIL reset_ctrl got=%b exp=110000",
                {wcmd_ready, rcmd_ready, wready, rvalid, wr_busy, rd_busy});
        else passed++;
        total++;
        if (rdata !== '0) $display("FAIL reset_rdata got=%h exp=0", rdata);
        else passed++;
    endtask

    task automatic test_single_beat();
        do_write(32'h40, 0);
        total++;
        if (rcmd_ready !== 1'b1) $display("FAIL single_rcmd_ready got=%b exp=1", rcmd_ready);
        else passed++;
        rcmd_valid = 1'b1;
        rcmd_addr = 32'h40;
        rcmd_len = 6'd0;
        tick();
        rcmd_valid = 1'b0;
        total++;
        if (rvalid !== 1'b1 || rdata !== model[1])
            $display("FAIL single_beat got=%b/%h exp=1/%h", rvalid, rdata, model[1]);
        else passed++;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        total++;
        if (rvalid !== 1'b0 || rd_busy !== 1'b0)
            $display("FAIL single_end got=%b%b exp=00", rvalid, rd_busy);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [511:0] hold;
        bit stalled;
        int got;
        do_write(32'h100, 3);
        rcmd_valid = 1'b1;
        rcmd_addr = 32'h100;
        rcmd_len = 6'd3;
        tick();
        rcmd_valid = 1'b0;
        stalled = 1'b0;
        got = 0;
        for (int k = 0; k < 40 && got < 4; k++) begin
            rready = (k % 3 == 0);
            if (stalled) begin
                total++;
                if (rvalid !== 1'b1 || rdata !== hold)
                    $display("FAIL bp_stable got=%b/%h exp=1/%h", rvalid, rdata, hold);
                else passed++;
            end
            stalled = 1'b0;
            if (rvalid && !rready) begin
                stalled = 1'b1;
                hold = rdata;
            end
            if (rvalid && rready) begin
                total++;
                if (rdata !== model[4 + got])
                    $display("FAIL bp_beat%0d got=%h exp=%h", got, rdata, model[4 + got]);
                else passed++;
                got++;
            end
            tick();
        end
        rready = 1'b0;
        total++;
        if (got != 4 || rvalid !== 1'b0)
            $display("FAIL bp_done got=%0d/%b exp=4/0", got, rvalid);
        else passed++;
    endtask

    task automatic test_wrap();
        do_write(32'hF80, 3);
        do_read(32'h0, 1, 1'b0);
        total++;
        if (rq.size() != 2) $display("FAIL wrap_count got=%0d exp=2", rq.size());
        else passed++;
        for (int i = 0; i < rq.size(); i++) begin
            total++;
            if (rq[i] !== model[i]) $display("FAIL wrap_beat%0d got=%h exp=%h", i, rq[i], model[i]);
            else passed++;
        end
    endtask

    task automatic test_concurrent();
        logic [511:0] old;
        logic [511:0] nv;
        do_write(32'd5 * 64, 0);
        do_write(32'd9 * 64, 0);
        rcmd_valid = 1'b1;
        rcmd_addr = 32'd5 * 64;
        rcmd_len = 6'd0;
        wcmd_valid = 1'b1;
        wcmd_addr = 32'd9 * 64;
        wcmd_len = 6'd0;
        total++;
        if ({wcmd_ready, rcmd_ready} !== 2'b11)
            $display("FAIL conc_readies got=%b exp=11", {wcmd_ready, rcmd_ready});
        else passed++;
        tick();
        rcmd_valid = 1'b0;
        wcmd_valid = 1'b0;
        total++;
        if ({wready, rvalid} !== 2'b11 || rdata !== model[5])
            $display("FAIL conc_accept got=%b%b/%h exp=11/%h", wready, rvalid, rdata, model[5]);
        else passed++;
        wvalid = 1'b1;
        wdata = rnd512();
        rready = 1'b1;
        tick();
        model[9] = wdata;
        wvalid = 1'b0;
        rready = 1'b0;
        total++;
        if ({wready, rvalid} !== 2'b00)
            $display("FAIL conc_idle got=%b%b exp=00", wready, rvalid);
        else passed++;
        // same-line hazard: load of line 9 in the cycle it is written
        wcmd_valid = 1'b1;
        wcmd_addr = 32'd9 * 64;
        wcmd_len = 6'd0;
        tick();
        wcmd_valid = 1'b0;
        old = model[9];
        nv = rnd512();
        wvalid = 1'b1;
        wdata = nv;
        rcmd_valid = 1'b1;
        rcmd_addr = 32'd9 * 64;
        rcmd_len = 6'd0;
        tick();
        wvalid = 1'b0;
        rcmd_valid = 1'b0;
        model[9] = nv;
        total++;
        if (rvalid !== 1'b1 || rdata !== old)
            $display("FAIL hazard_old got=%b/%h exp=1/%h", rvalid, rdata, old);
        else passed++;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        do_read(32'd9 * 64, 0, 1'b0);
        total++;
        if (rq.size() != 1 || rq[0] !== nv)
            $display("FAIL hazard_new got=%0d exp=1 beat", rq.size());
        else passed++;
    endtask

    task automatic test_reset_mid_burst();
        wcmd_valid = 1'b1;
        wcmd_addr = 32'h0;
        wcmd_len = 6'd7;
        tick();
        wcmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1;
            wdata = rnd512();
            tick();
            model[i] = wdata;
        end
        wvalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({wready, wcmd_ready, wr_busy} !== 3'b010)
            $display("FAIL rstmid_ctrl got=%b exp=010", {wready, wcmd_ready, wr_busy});
        else passed++;
        do_read(32'h0, 1, 1'b1);
        total++;
        if (rq.size() != 2) $display("FAIL rstmid_count got=%0d exp=2", rq.size());
        else passed++;
        for (int i = 0; i < rq.size(); i++) begin
            total++;
            if (rq[i] !== model[i]) $display("FAIL rstmid_beat%0d got=%h exp=%h", i, rq[i], model[i]);
            else passed++;
        end
    endtask

    task automatic test_ignored_addr();
        do_write(32'hFFFF_0047, 0);
        do_read(32'h40, 0, 1'b0);
        total++;
        if (rq.size() != 1 || rq[0] !== model[1])
            $display("FAIL ign_addr got=%0d beats exp=1 matching line 1", rq.size());
        else passed++;
    endtask

    task automatic test_random();
        logic [31:0] a;
        int len;
        int ln;
        do_write(32'h0, 63);
        do_read(32'h0, 63, 1'b1);
        total++;
        if (rq.size() != 64) $display("FAIL full_count got=%0d exp=64", rq.size());
        else passed++;
        for (int i = 0; i < rq.size(); i++) begin
            total++;
            if (rq[i] !== model[i]) $display("FAIL full_beat%0d got=%h exp=%h", i, rq[i], model[i]);
            else passed++;
        end
        for (int t = 0; t < 20; t++) begin
            a = $urandom;
            len = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, len);
            end else begin
                ln = line_of(a);
                do_read(a, len, 1'b1);
                total++;
                if (rq.size() != len + 1)
                    $display("FAIL rnd%0d_count got=%0d exp=%0d", t, rq.size(), len + 1);
                else passed++;
                for (int i = 0; i < rq.size(); i++) begin
                    total++;
                    if (rq[i] !== model[(ln + i) % D])
                        $display("FAIL rnd%0d_beat%0d got=%h exp=%h", t, i, rq[i], model[(ln + i) % D]);
                    else passed++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_backpressure();
        test_wrap();
        test_concurrent();
        test_reset_mid_burst();
        test_ignored_addr();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/umai_mem_responder.md
# umai_mem_responder

Behavioural UMAI target that terminates a UMAI master port, such as the chiplet-1 side of the two-chiplet model. It accepts write and read commands, stores write bursts in an internal line-addressed memory, and returns read bursts with ready/valid backpressure. It closes the loop in chiplet-to-chiplet simulations, so end-to-end data integrity can be checked without an external memory model.

## Interface
Parameters:
- Depth, 64: number of 512-bit lines in the memory; must be a power of two, ≥2.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_umai_wcmd_valid  in  1  write command valid.
- o_umai_wcmd_ready  out  1  write command ready.
- i_umai_wcmd_addr  in  32  write byte address.
- i_umai_wcmd_len  in  6  write burst length minus 1.
- i_umai_rcmd_valid  in  1  read command valid.
- o_umai_rcmd_ready  out  1  read command ready.
- i_umai_rcmd_addr  in  32  read byte address.
- i_umai_rcmd_len  in  6  read burst length minus 1.
- i_umai_wvalid  in  1  write data valid.
- o_umai_wready  out  1  write data ready.
- i_umai_wdata  in  512  write data beat.
- o_umai_rvalid  out  1  read data valid.
- i_umai_rready  in  1  read data ready.
- o_umai_rdata  out  512  read data beat.
- o_wr_busy  out  1  write engine not idle.
- o_rd_busy  out  1  read engine not idle.

## Operation
- Beat count = len+1, so 1..64 beats per burst.
- Line index = addr[6 +: log2(Depth)]. addr[5:0] and the upper bits are ignored.
- Each beat advances the index by 1, modulo Depth; it wraps silently.
- Write and read engines are independent and may run concurrently.
- Write FSM:
  - W_IDLE: o_umai_wcmd_ready=1, o_umai_wready=0. wcmd handshake latches the index and beat count, then → W_DATA.
  - W_DATA: o_umai_wcmd_ready=0, o_umai_wready=1. Each wvalid&wready writes wdata to mem[index], increments index, decrements count. The last beat → W_IDLE.
- Read FSM:
  - R_IDLE: o_umai_rcmd_ready=1, o_umai_rvalid=0. rcmd handshake loads o_umai_rdata ← mem[index], latches index+1 and count, then → R_DATA.
  - R_DATA: o_umai_rcmd_ready=0, o_umai_rvalid=1, o_umai_rdata held stable until rvalid&rready.
    - On a non-last handshake: reload o_umai_rdata ← mem[next index], advance index, stay in R_DATA.
    - On the last handshake: → R_IDLE; o_umai_rdata keeps its last value.
- Memory hazard: a load of o_umai_rdata from line X in the same cycle as a write to line X captures the old contents (read-before-write). A load in any later cycle sees the new data.
- Memory contents are not reset; they are X until written.
- o_wr_busy = (W_DATA), o_rd_busy = (R_DATA).

## Timing
- Reset values: o_umai_wcmd_ready=1, o_umai_rcmd_ready=1, o_umai_wready=0, o_umai_rvalid=0, o_umai_rdata=0, o_wr_busy=0, o_rd_busy=0. Both FSMs go to IDLE; index and count registers clear.
- The ready outputs in the reset values above take effect from the first cycle after i_rst is sampled high.
- Reset mid-burst: the burst is abandoned and no further beats are accepted or returned. Lines already written keep their data.
- wcmd accepted in cycle N → o_umai_wready=1 in cycle N+1.
- rcmd accepted in cycle N → o_umai_rvalid=1 with the first beat in cycle N+1.
- Sustained throughput is 1 beat/cycle on each engine while the peer is ready/valid.
- Commands are accepted only in IDLE, so the minimum command-to-command spacing is burst length + 1 cycles.
- wdata presented while in W_IDLE is not accepted (wready=0). No skid buffer.
- rvalid never drops before its handshake, and rdata never changes while rvalid=1 and rready=0.
- Simultaneous wcmd and rcmd in IDLE: both are accepted in the same cycle.

## Structure
- Shared package umai_pkg holds:
  - UMAI widths: AddrW=32, LenW=6, DataW=512.
  - BeatBytes=64 and the line-offset constant (6).
  - Write FSM state typedef {W_IDLE, W_DATA}.
  - Read FSM state typedef {R_IDLE, R_DATA}.
- Sub-module umai_resp_mem: a Depth×512 array with one synchronous write port and one registered read port (read-before-write). It has no reset on the array.
- The top-level instantiates umai_resp_mem plus the two FSMs.

## Test plan
- Single beat: wcmd addr=0x40, len=0, wdata=A; then rcmd addr=0x40, len=0 → one rvalid beat with rdata=A, in the cycle after rcmd is accepted.
- Burst with backpressure: write 4 beats D0..D3 at addr 0x100; read len=3 with rready toggling 1,0,0,1,… → D0..D3 in order, rdata stable while stalled, rvalid deasserts after D3.
- Wrap-around (Depth=64): write len=3 at addr 0xF80 (line 62) → lines 62,63,0,1. Read len=1 at addr 0x0 → beats 3 and 4 of the write.
- Concurrent engines: rcmd to line 5 issued the same cycle as a wcmd to line 9 → both are accepted in that cycle. A concurrent same-line write during the rdata load → old data is returned.
- Reset mid-burst: assert i_rst after 2 of 8 write beats → next cycle wready=0, wcmd_ready=1. A subsequent read of lines 0-1 returns the 2 written beats.
- Ignored address bits: wcmd addr=0xFFFF_0047 targets line 1 (Depth=64). A read at 0x40 returns the same data.
